video_mode_ctrl: RTL and testbench
==================================

// Module: video_mode_ctrl
// PURPOSE
//   Sequences glitch-free video mode changes for the video_timing generator. Accepts new
//   timing configs over a valid/ready port, validates them, and waits for a frame boundary
//   (vsync edge). It then blanks output for BLANK_FRAMES frames, loads the config into the
//   generator with a one-cycle strobe, and holds blank for SETTLE_FRAMES frames on the new
//   timing before releasing. Sits between the host/config logic and video_timing.
// PARAMETERS
//   HW            12    width of horizontal timing fields
//   VW            11    width of vertical timing fields
//   DEF_H_ACTIVE  640   reset value of cfg_h_active
//   DEF_H_TOTAL   800   reset value of cfg_h_total
//   DEF_V_ACTIVE  480   reset value of cfg_v_active
//   DEF_V_TOTAL   525   reset value of cfg_v_total
//   VS_POL        0     active level of vsync (0 = active-low)
//   BLANK_FRAMES  1     frames blanked before load (0 = load at first boundary)
//   SETTLE_FRAMES 2     frames blanked after load (0 = release right after load)
//   TIMEOUT_CYC   2000000  cycles without a vsync edge before a synthetic boundary
// PORTS
//   clk           in   1   pixel clock; all logic on rising edge
//   rst           in   1   synchronous reset, active-high
//   vsync         in   1   vsync from video_timing
//   req_valid     in   1   new config offered
//   req_ready     out  1   controller can accept a config
//   req_h_active  in   HW  requested active pixels per line
//   req_h_total   in   HW  requested total pixels per line
//   req_v_active  in   VW  requested active lines
//   req_v_total   in   VW  requested total lines
//   req_err       out  1   1-cycle pulse: offered config rejected
//   done          out  1   1-cycle pulse: mode change complete
//   busy          out  1   mode change in progress
//   blank         out  1   force video output to black
//   cfg_h_active  out  HW  timing config to video_timing (same for h_total/v_active/v_total)
//   cfg_h_total   out  HW
//   cfg_v_active  out  VW
//   cfg_v_total   out  VW
//   cfg_load      out  1   1-cycle strobe: video_timing restarts counters with cfg_*
// BEHAVIOUR
//   Reset: state IDLE; cfg_* = DEF_*; req_ready=1; blank, busy, cfg_load, req_err, done = 0;
//     pending regs, frame and timeout counters cleared. Reset mid-change aborts it entirely.
//   Boundary event: vs_q = vsync registered; edge = (vsync==VS_POL) && (vs_q!=VS_POL).
//     Alternatively, the timeout counter reaching TIMEOUT_CYC-1 counts as an edge. The
//     counter clears on any edge and runs only outside IDLE.
//   req_ready = (state==IDLE). Transfer = req_valid && req_ready.
//   Validation on transfer: reject if any field is 0, h_active>=h_total or v_active>=v_total.
//     Reject -> req_err=1 next cycle, stay IDLE, cfg_* unchanged.
//     Accept -> latch fields into pending regs; next cycle state WAIT_FRAME, busy=1, ready=0.
//   States:
//     IDLE       -> WAIT_FRAME on an accepted transfer.
//     WAIT_FRAME -> on edge: blank=1 from next cycle; BLANK (fcnt=0), or LOAD if BLANK_FRAMES==0.
//     BLANK      -> each edge increments fcnt; on the edge making fcnt==BLANK_FRAMES -> LOAD.
//     LOAD       -> exactly one cycle: cfg_*<=pending, cfg_load=1; -> SETTLE (fcnt=0).
//                   If SETTLE_FRAMES==0, go directly to release (IDLE).
//     SETTLE     -> counts edges as BLANK; on fcnt==SETTLE_FRAMES -> IDLE: blank=0, busy=0,
//                   done=1 for one cycle, ready=1 in the same cycle.
//   cfg_* change only in the LOAD cycle; stable otherwise. blank=1 throughout BLANK/LOAD/SETTLE.
//   An edge coincident with the cycle entering a state is not counted in that state.
//   Edges and the timeout are ignored in IDLE and LOAD.
//   req_valid during busy: ignored (ready=0), no err. done and req_err never assert together.
// TESTING
//   Use a fast timing model: vsync pulse every 1000 clk; BLANK_FRAMES=1, SETTLE_FRAMES=2,
//     TIMEOUT_CYC=3000.
//   1 Reset: cfg_* = 640/800/480/525, ready=1, blank=0, busy=0; rst pulse mid-SETTLE ->
//     same values next cycle.
//   2 Valid req 800/1056/600/628 -> busy next clk; blank rises 1 clk after the first vsync
//     edge; cfg_load pulses once 1 clk after the next edge with cfg_* = new values;
//     blank falls and done pulses 1 clk after the 2nd edge following the load.
//   3 Invalid reqs (h_active=800,h_total=800; v_total=0) -> req_err 1-cycle pulse each,
//     cfg_* unchanged, busy stays 0.
//   4 Hold vsync inactive after accept -> a synthetic boundary every 3000 clk; sequence
//     still completes with a single cfg_load.
//   5 Second req_valid while busy -> ready=0, no err; accepted only after done,
//     back-to-back changes both applied in order.
//   6 Vsync edge in the same cycle as the accept -> not counted; blanking starts at the
//     following edge.

Source files
------------

// File: rtl/video_mode_ctrl.sv
// Mode-change sequencer for video_timing: accepts a timing config, waits for a frame
// boundary, blanks, strobes the new config into the generator and settles before release.
module video_mode_ctrl #(
  parameter int unsigned HW            = 12,
  parameter int unsigned VW            = 11,
  parameter int unsigned DEF_H_ACTIVE  = 640,
  parameter int unsigned DEF_H_TOTAL   = 800,
  parameter int unsigned DEF_V_ACTIVE  = 480,
  parameter int unsigned DEF_V_TOTAL   = 525,
  parameter int unsigned VS_POL        = 0,
  parameter int unsigned BLANK_FRAMES  = 1,
  parameter int unsigned SETTLE_FRAMES = 2,
  parameter int unsigned TIMEOUT_CYC   = 2000000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vsync,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [HW-1:0] req_h_active,
  input  logic [HW-1:0] req_h_total,
  input  logic [VW-1:0] req_v_active,
  input  logic [VW-1:0] req_v_total,
  output logic          req_err,
  output logic          done,
  output logic          busy,
  output logic          blank,
  output logic [HW-1:0] cfg_h_active,
  output logic [HW-1:0] cfg_h_total,
  output logic [VW-1:0] cfg_v_active,
  output logic [VW-1:0] cfg_v_total,
  output logic          cfg_load
);

  localparam logic        VS_LVL = (VS_POL != 0);
  localparam int unsigned FMAX   = (BLANK_FRAMES > SETTLE_FRAMES) ? BLANK_FRAMES : SETTLE_FRAMES;
  localparam int unsigned FW     = $clog2(FMAX + 2);
  localparam int unsigned TW     = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [FW-1:0] BLANK_N  = FW'(BLANK_FRAMES);
  localparam logic [FW-1:0] SETTLE_N = FW'(SETTLE_FRAMES);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_BLANK, S_LOAD, S_SETTLE} state_t;

  state_t        state_q;
  logic          vs_q;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [HW-1:0] pha_q, pht_q, cha_q, cht_q;
  logic [VW-1:0] pva_q, pvt_q, cva_q, cvt_q;
  logic          busy_q, blank_q, load_q, done_q, err_q;
  logic          frame_edge, req_ok, do_load, do_release;

  always_comb begin
    // A missing vsync must not stall a change forever, so the timeout stands in for an edge.
    frame_edge = ((vsync == VS_LVL) && (vs_q != VS_LVL)) || (tcnt_q == TO_LAST);
    fcnt_d     = fcnt_q + 1'b1;
    tcnt_d     = ((state_q == S_IDLE) || frame_edge) ? '0 : tcnt_q + 1'b1;
    req_ok     = (req_h_active != '0) && (req_h_total != '0) &&
                 (req_v_active != '0) && (req_v_total != '0) &&
                 (req_h_active < req_h_total) && (req_v_active < req_v_total);
    do_load    = ((state_q == S_WAIT) && frame_edge && (BLANK_FRAMES == 0)) ||
                 ((state_q == S_BLANK) && frame_edge && (fcnt_d == BLANK_N));
    do_release = ((state_q == S_LOAD) && (SETTLE_FRAMES == 0)) ||
                 ((state_q == S_SETTLE) && frame_edge && (fcnt_d == SETTLE_N));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vs_q    <= VS_LVL;
      tcnt_q  <= '0;
      fcnt_q  <= '0;
      pha_q   <= '0;
      pht_q   <= '0;
      pva_q   <= '0;
      pvt_q   <= '0;
      cha_q   <= HW'(DEF_H_ACTIVE);
      cht_q   <= HW'(DEF_H_TOTAL);
      cva_q   <= VW'(DEF_V_ACTIVE);
      cvt_q   <= VW'(DEF_V_TOTAL);
      busy_q  <= 1'b0;
      blank_q <= 1'b0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      vs_q   <= vsync;
      tcnt_q <= tcnt_d;
      load_q <= do_load;
      done_q <= do_release;
      err_q  <= 1'b0;
      if (do_load) begin
        cha_q <= pha_q;
        cht_q <= pht_q;
        cva_q <= pva_q;
        cvt_q <= pvt_q;
      end
      if (do_release) begin
        blank_q <= 1'b0;
        busy_q  <= 1'b0;
      end
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            if (req_ok) begin
              pha_q   <= req_h_active;
              pht_q   <= req_h_total;
              pva_q   <= req_v_active;
              pvt_q   <= req_v_total;
              busy_q  <= 1'b1;
              state_q <= S_WAIT;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (frame_edge) begin
            blank_q <= 1'b1;
            fcnt_q  <= '0;
            state_q <= do_load ? S_LOAD : S_BLANK;
          end
        end
        S_BLANK: begin
          if (frame_edge) begin
            fcnt_q <= fcnt_d;
            if (do_load) state_q <= S_LOAD;
          end
        end
        // Edges landing in the load cycle belong to the old timing and are dropped.
        S_LOAD: begin
          fcnt_q  <= '0;
          state_q <= do_release ? S_IDLE : S_SETTLE;
        end
        S_SETTLE: begin
          if (frame_edge) begin
            fcnt_q <= fcnt_d;
            if (do_release) state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready    = (state_q == S_IDLE);
  assign busy         = busy_q;
  assign blank        = blank_q;
  assign cfg_load     = load_q;
  assign done         = done_q;
  assign req_err      = err_q;
  assign cfg_h_active = cha_q;
  assign cfg_h_total  = cht_q;
  assign cfg_v_active = cva_q;
  assign cfg_v_total  = cvt_q;

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Bench for video_mode_ctrl: frame-count reference model compared every cycle, plus
// directed scenarios with hand-derived timings and configs.
module tb_video_mode_ctrl;
  localparam int HW = 12, VW = 11, BF = 1, SF = 2, TO = 3000, PER = 1000, PW = 4;
  localparam logic [45:0] DEF_CFG = {12'd640, 12'd800, 11'd480, 11'd525};

  logic clk = 1'b0;
  logic rst, vsync, req_valid;
  logic req_ready, req_err, done, busy, blank, cfg_load;
  logic [HW-1:0] req_h_active, req_h_total, cfg_h_active, cfg_h_total;
  logic [VW-1:0] req_v_active, req_v_total, cfg_v_active, cfg_v_total;

  always #5 clk = ~clk;

  video_mode_ctrl #(
    .HW(HW), .VW(VW), .DEF_H_ACTIVE(640), .DEF_H_TOTAL(800), .DEF_V_ACTIVE(480),
    .DEF_V_TOTAL(525), .VS_POL(0), .BLANK_FRAMES(BF), .SETTLE_FRAMES(SF), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .vsync(vsync), .req_valid(req_valid), .req_ready(req_ready),
    .req_h_active(req_h_active), .req_h_total(req_h_total), .req_v_active(req_v_active),
    .req_v_total(req_v_total), .req_err(req_err), .done(done), .busy(busy), .blank(blank),
    .cfg_h_active(cfg_h_active), .cfg_h_total(cfg_h_total), .cfg_v_active(cfg_v_active),
    .cfg_v_total(cfg_v_total), .cfg_load(cfg_load)
  );

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int n_load = 0, n_err = 0, cyc_n = 0, vphase = 0;
  bit chk_en = 1'b0, vs_en = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 25) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  // Reference model: progress of a change is the number of frame boundaries seen since
  // the accept; blank after the 1st, load after BF+1, release after BF+SF+1.
  bit m_busy = 0, m_blank = 0, m_load = 0, m_done = 0, m_err = 0, m_prev = 1;
  int m_nb = 0, m_quiet = 0;
  logic [45:0] m_cfg = DEF_CFG, m_pend = '0;

  function automatic bit cfg_ok(int ha, int ht, int va, int vt);
    return ha != 0 && ht != 0 && va != 0 && vt != 0 && ha < ht && va < vt;
  endfunction

  always @(posedge clk) begin
    bit bnd, was_load;
    if (rst) begin
      m_busy = 0; m_blank = 0; m_load = 0; m_done = 0; m_err = 0;
      m_nb = 0; m_quiet = 0; m_prev = 1; m_cfg = DEF_CFG; m_pend = '0;
    end else begin
      bnd = (vsync == 1'b0 && m_prev != 1'b0) || (m_busy && m_quiet == TO - 1);
      was_load = m_load;
      m_load = 0; m_done = 0; m_err = 0;
      if (!m_busy) begin
        m_quiet = 0;
        if (req_valid) begin
          if (cfg_ok(req_h_active, req_h_total, req_v_active, req_v_total)) begin
            m_pend = {req_h_active, req_h_total, req_v_active, req_v_total};
            m_busy = 1; m_nb = 0;
          end else m_err = 1;
        end
      end else begin
        m_quiet = bnd ? 0 : m_quiet + 1;
        if (was_load) begin
          if (SF == 0) begin m_busy = 0; m_blank = 0; m_done = 1; end
        end else if (bnd) begin
          m_nb++;
          if (m_nb == 1) m_blank = 1;
          if (m_nb == 1 + BF) begin m_load = 1; m_cfg = m_pend; end
          if (SF > 0 && m_nb == 1 + BF + SF) begin m_busy = 0; m_blank = 0; m_done = 1; end
        end
      end
      m_prev = vsync;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ctrl rdy/busy/blank/load/done/err", {req_ready, busy, blank, cfg_load, done, req_err},
          {!m_busy, m_busy, m_blank, m_load, m_done, m_err});
      chk("cfg", {cfg_h_active, cfg_h_total, cfg_v_active, cfg_v_total}, m_cfg);
    end
    if (cfg_load === 1'b1) n_load++;
    if (req_err === 1'b1) n_err++;
  end

  task automatic cyc();
    @(negedge clk);
    cyc_n++;
    vphase = (vphase + 1) % PER;
    vsync = (vs_en && vphase < PW) ? 1'b0 : 1'b1;
  endtask

  function automatic bit sig(int sel);
    case (sel)
      0: return blank === 1'b1;
      1: return cfg_load === 1'b1;
      2: return done === 1'b1;
      default: return busy === 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int budget, output int t);
    int cnt = 0;
    while (!sig(sel) && cnt < budget) begin cyc(); cnt++; end
    if (!sig(sel)) chk($sformatf("wait sel=%0d timed out", sel), 0, 1);
    t = cyc_n;
  endtask

  task automatic send(input int ha, input int ht, input int va, input int vt);
    req_h_active = HW'(ha); req_h_total = HW'(ht);
    req_v_active = VW'(va); req_v_total = VW'(vt);
    req_valid = 1'b1;
    cyc();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle_junk(input int budget);
    int cnt = 0;
    while (busy !== 1'b0 && cnt < budget) begin
      req_valid = ($urandom_range(0, 7) == 0);
      req_h_active = HW'($urandom); req_h_total = HW'($urandom);
      req_v_active = VW'($urandom); req_v_total = VW'($urandom);
      cyc(); cnt++;
    end
    req_valid = 1'b0;
    if (busy !== 1'b0) chk("random wait idle timed out", 0, 1);
  endtask

  initial begin
    #(150000 * 10);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, t3, l0, e0, ha, ht, va, vt;
    rst = 1'b1; vsync = 1'b1; req_valid = 1'b0;
    req_h_active = '0; req_h_total = '0; req_v_active = '0; req_v_total = '0;
    repeat (3) cyc();
    chk_en = 1'b1;
    // Reset values
    chk("t1 reset cfg", {cfg_h_active, cfg_h_total, cfg_v_active, cfg_v_total},
        {12'd640, 12'd800, 11'd480, 11'd525});
    chk("t1 reset rdy/busy/blank", {req_ready, busy, blank}, 3'b100);
    rst = 1'b0;
    repeat (5) cyc();

    // Basic change
    l0 = n_load;
    send(800, 1056, 600, 628);
    chk("t2 busy after accept", {busy, req_ready}, 2'b10);
    wait_for(0, 2000, t1);
    wait_for(1, 2000, t2);
    chk("t2 cfg at load", {cfg_h_active, cfg_h_total, cfg_v_active, cfg_v_total},
        {12'd800, 12'd1056, 11'd600, 11'd628});
    wait_for(2, 4000, t3);
    chk("t2 blank->load cycles", t2 - t1, 1000);
    chk("t2 load->done cycles", t3 - t2, 2000);
    chk("t2 at done rdy/busy/blank", {req_ready, busy, blank}, 3'b100);
    chk("t2 load count", n_load - l0, 1);
    cyc();

    // Invalid requests
    e0 = n_err;
    send(800, 800, 600, 628);
    chk("t3 err pulse a", {req_err, busy}, 2'b10);
    cyc();
    chk("t3 err cleared", req_err, 0);
    send(800, 1056, 600, 0);
    chk("t3 err pulse b", {req_err, busy}, 2'b10);
    cyc();
    chk("t3 err count", n_err - e0, 2);
    chk("t3 cfg unchanged", {cfg_h_active, cfg_h_total, cfg_v_active, cfg_v_total},
        {12'd800, 12'd1056, 11'd600, 11'd628});

    // Reset in the middle of the settle phase
    send(1024, 1344, 768, 806);
    wait_for(1, 4000, t0);
    repeat (500) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t1b reset mid-settle cfg", {cfg_h_active, cfg_h_total, cfg_v_active, cfg_v_total},
        {12'd640, 12'd800, 11'd480, 11'd525});
    chk("t1b reset mid-settle rdy/busy/blank", {req_ready, busy, blank}, 3'b100);
    repeat (3) cyc();

    // Accept in the same cycle as a vsync edge
    for (int i = 0; i < PER && vphase != 0; i++) cyc();
    send(1280, 1688, 1024, 1066);
    t0 = cyc_n;
    wait_for(0, 3000, t1);
    chk("t6 blank latency from coincident accept", t1 - t0, 1000);
    wait_for(3, 5000, t1);

    // Vsync held inactive: timeout boundaries every TO cycles
    vs_en = 1'b0;
    cyc();
    l0 = n_load;
    send(720, 858, 480, 525);
    t0 = cyc_n;
    wait_for(0, 4000, t1);
    wait_for(1, 4000, t2);
    wait_for(2, 7000, t3);
    chk("t4 blank at timeout", t1 - t0, 3000);
    chk("t4 load at timeout", t2 - t0, 6000);
    chk("t4 done at timeout", t3 - t0, 12000);
    chk("t4 load count", n_load - l0, 1);
    vs_en = 1'b1;
    repeat (3) cyc();

    // Request held while busy, then accepted back-to-back
    l0 = n_load; e0 = n_err;
    send(1280, 1650, 720, 750);
    req_h_active = 12'd1920; req_h_total = 12'd2200; req_v_active = 11'd1080; req_v_total = 11'd1125;
    req_valid = 1'b1;
    chk("t5 ready low while busy", req_ready, 0);
    wait_for(2, 6000, t1);
    chk("t5 cfg A at done", {cfg_h_active, cfg_h_total, cfg_v_active, cfg_v_total},
        {12'd1280, 12'd1650, 11'd720, 11'd750});
    cyc();
    req_valid = 1'b0;
    chk("t5 busy after second accept", busy, 1);
    wait_for(3, 6000, t2);
    chk("t5 cfg B final", {cfg_h_active, cfg_h_total, cfg_v_active, cfg_v_total},
        {12'd1920, 12'd2200, 11'd1080, 11'd1125});
    chk("t5 load count", n_load - l0, 2);
    chk("t5 no err while busy", n_err - e0, 0);

    // Randomized changes with junk requests during busy
    for (int r = 0; r < 5; r++) begin
      repeat ($urandom_range(1, 800)) cyc();
      ht = $urandom_range(2, 4095); ha = $urandom_range(1, ht - 1);
      vt = $urandom_range(2, 2047); va = $urandom_range(1, vt - 1);
      if (r == 1) ha = ht;
      if (r == 3) va = 0;
      send(ha, ht, va, vt);
      if (cfg_ok(ha, ht, va, vt)) wait_idle_junk(6000);
      else cyc();
    end
    repeat (5) cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
